axi_config_regbank: RTL and testbench
=====================================

# axi_config_regbank

Register bank sitting directly downstream of the AXI config bridge. It consumes the bridge's simple `wr`/`waddr`/`wdata`/`wstrb` write strobe and `rd`/`raddr` read strobe, and returns `rdata`/`rvalid` with fixed one-cycle latency. It holds byte-writable control registers, one read-only status word, and an interrupt pending/mask pair. It drives a level interrupt from the pending/mask pair.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: register width; multiple of 8.
- `STRB_WIDTH`, `DATA_WIDTH/8`: byte strobe width.
- `NUM_CTRL`, 4: number of RW control registers; 1..64.
- `CTRL_RESET`, 0: reset value of every control register.
- `VERSION`, 32'h0001_0000: value of the read-only ID register.
- `BASE_ADDR`, 0: byte base address of the bank; aligned to `2**ADDR_WIDTH`-safe power of two ≥ map size.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `raddr`  in  `ADDR_WIDTH`  read byte address.
- `rd`  in  1  read strobe, one cycle per access.
- `rdata`  out  `DATA_WIDTH`  read data, valid with `rvalid`.
- `rvalid`  out  1  read response strobe.
- `wr`  in  1  write strobe, one cycle per access.
- `waddr`  in  `ADDR_WIDTH`  write byte address.
- `wdata`  in  `DATA_WIDTH`  write data.
- `wstrb`  in  `STRB_WIDTH`  byte enables.
- `ctrl_out`  out  `NUM_CTRL*DATA_WIDTH`  flat control register contents; register k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `ctrl_wr_pulse`  out  `NUM_CTRL`  one-cycle pulse per control register written.
- `status_in`  in  `DATA_WIDTH`  live status, synchronous to `clk`.
- `irq_event`  in  `DATA_WIDTH`  per-bit event pulses.
- `irq`  out  1  level interrupt.

## Operation
- Word index = (addr − `BASE_ADDR`) >> log2(`STRB_WIDTH`); low byte-offset bits ignored. Addresses below `BASE_ADDR` are unmapped.
- Map (by word index):
  - 0..`NUM_CTRL`−1: CTRL[k], RW.
  - `NUM_CTRL`: STATUS, RO, equals `status_in` sampled in the `rd` cycle.
  - `NUM_CTRL`+1: IRQ_PEND, W1C.
  - `NUM_CTRL`+2: IRQ_MASK, RW.
  - `NUM_CTRL`+3: ID, RO, equals `VERSION`.
- Unmapped reads return 0 with normal `rvalid`. Unmapped writes and writes to RO registers are ignored.
- RW writes: only bytes with `wstrb` set are updated. `ctrl_wr_pulse[k]` fires whenever `wr` hits CTRL[k], regardless of `wstrb`.
- IRQ_PEND next = (pend & ~(wdata & bytemask(wstrb))) | `irq_event`. Set wins over a same-cycle clear.
- `irq` = |(IRQ_PEND & IRQ_MASK), taken from registers only (glitch-free).
- `rd` and `wr` in the same cycle are both serviced. If both target the same register, the read returns the pre-write value.
- Back-to-back `rd` every cycle is supported; each `rd` produces exactly one `rvalid`. No backpressure exists.

## Timing
- Reset (async assert, sync release): `rvalid`=0, `rdata`=0, `ctrl_out`=`CTRL_RESET` in every slot, `ctrl_wr_pulse`=0, IRQ_PEND=0, IRQ_MASK=0, `irq`=0.
- Read: `rd` sampled at edge N; `rdata`/`rvalid` valid after edge N+1 for exactly one cycle. `rdata` holds its last value while `rvalid`=0.
- Write: `wr` sampled at edge N.
  - `ctrl_out`, IRQ_MASK and IRQ_PEND update at N+1.
  - `ctrl_wr_pulse` is high for the cycle following N+1.
  - `irq` reflects the update at N+1.
- `irq_event` bit high at edge N: IRQ_PEND bit set at N+1; `irq` high at N+1 if the bit is masked in.
- A read at edge N+1 observes a write made at edge N.
- Reset asserted with a read outstanding: the response is dropped; `rvalid` is forced low immediately.

## Test plan
- Reset with `CTRL_RESET`=32'hA5A5_0000, NUM_CTRL=4 -> all `ctrl_out` slots 32'hA5A5_0000, `irq`=0; reading index 7 returns 32'h0001_0000 one cycle after `rd`.
- Write CTRL[2] with wdata 32'h1122_3344, `wstrb`=4'b0101 over reset value 0 -> CTRL[2]=32'h0022_0044; `ctrl_wr_pulse`=4'b0100 for one cycle; readback matches.
- Back-to-back `rd` to index 0,1,4,9 (`status_in`=32'hCAFE) -> four consecutive `rvalid` cycles with data CTRL0, CTRL1, 32'hCAFE, 0.
- Set IRQ_MASK=32'h1. Pulse `irq_event`=32'h3 -> IRQ_PEND=3 and `irq`=1. Write IRQ_PEND=32'h1 -> IRQ_PEND=2 and `irq`=0. Repeat the W1C in the same cycle as `irq_event`=1 -> bit 0 stays set.
- Same-cycle `rd` and `wr` to CTRL[0] (old 0, new 32'hFFFF_FFFF) -> `rdata`=0; the next read returns 32'hFFFF_FFFF.
- Assert `rst` in the cycle after a `rd` -> no `rvalid`; all outputs at reset values.

Source files
------------

// File: rtl/axi_config_regbank.sv
// Configuration register bank behind the AXI config bridge: byte-writable control
// registers, a live status word, an interrupt pending/mask pair and a read-only ID.
module axi_config_regbank #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                    NUM_CTRL   = 4,
  parameter logic [DATA_WIDTH-1:0] CTRL_RESET = '0,
  parameter logic [DATA_WIDTH-1:0] VERSION    = 32'h0001_0000,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          raddr,
  input  logic                           rd,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rvalid,
  input  logic                           wr,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB_WIDTH-1:0]          wstrb,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_out,
  output logic [NUM_CTRL-1:0]            ctrl_wr_pulse,
  input  logic [DATA_WIDTH-1:0]          status_in,
  input  logic [DATA_WIDTH-1:0]          irq_event,
  output logic                           irq
);

  localparam int OFF_BITS = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] IDX_STATUS = ADDR_WIDTH'(NUM_CTRL);
  localparam logic [ADDR_WIDTH-1:0] IDX_PEND   = ADDR_WIDTH'(NUM_CTRL + 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_MASK   = ADDR_WIDTH'(NUM_CTRL + 2);
  localparam logic [ADDR_WIDTH-1:0] IDX_ID     = ADDR_WIDTH'(NUM_CTRL + 3);

  logic [DATA_WIDTH-1:0] ctrl [NUM_CTRL];
  logic [DATA_WIDTH-1:0] irq_pend;
  logic [DATA_WIDTH-1:0] irq_mask;

  logic                  r_in_range, w_in_range;
  logic [ADDR_WIDTH-1:0] ridx, widx;
  logic [DATA_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] read_mux;
  logic [NUM_CTRL-1:0]   ctrl_hit;
  logic                  pend_hit, mask_hit;
  logic [DATA_WIDTH-1:0] pend_clr;

  // Addresses below the base would wrap on subtraction, so they are flagged unmapped.
  assign r_in_range = (raddr >= BASE_ADDR);
  assign w_in_range = (waddr >= BASE_ADDR);
  assign ridx       = (raddr - BASE_ADDR) >> OFF_BITS;
  assign widx       = (waddr - BASE_ADDR) >> OFF_BITS;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < STRB_WIDTH; i++)
      byte_mask[i*8 +: 8] = {8{wstrb[i]}};
  end

  always_comb begin
    read_mux = '0;
    if (r_in_range) begin
      for (int k = 0; k < NUM_CTRL; k++)
        if (ridx == ADDR_WIDTH'(k)) read_mux = ctrl[k];
      if (ridx == IDX_STATUS) read_mux = status_in;
      if (ridx == IDX_PEND)   read_mux = irq_pend;
      if (ridx == IDX_MASK)   read_mux = irq_mask;
      if (ridx == IDX_ID)     read_mux = VERSION;
    end
  end

  always_comb begin
    ctrl_hit = '0;
    for (int k = 0; k < NUM_CTRL; k++)
      ctrl_hit[k] = wr && w_in_range && (widx == ADDR_WIDTH'(k));
  end

  assign pend_hit = wr && w_in_range && (widx == IDX_PEND);
  assign mask_hit = wr && w_in_range && (widx == IDX_MASK);
  assign pend_clr = pend_hit ? (wdata & byte_mask) : '0;

  always_comb begin
    ctrl_out = '0;
    for (int k = 0; k < NUM_CTRL; k++)
      ctrl_out[k*DATA_WIDTH +: DATA_WIDTH] = ctrl[k];
  end

  // NOTE: sequential state uses non-blocking assignments so a same-cycle read sees the pre-write value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid        <= 1'b0;
      rdata         <= '0;
      ctrl_wr_pulse <= '0;
      irq_pend      <= '0;
      irq_mask      <= '0;
      // NOTE: the control array is a handful of flops with a defined reset value, not a RAM, so it is reset.
      for (int k = 0; k < NUM_CTRL; k++) ctrl[k] <= CTRL_RESET;
    end else begin
      rvalid        <= rd;
      if (rd) rdata <= read_mux;
      ctrl_wr_pulse <= ctrl_hit;
      for (int k = 0; k < NUM_CTRL; k++)
        if (ctrl_hit[k]) ctrl[k] <= (ctrl[k] & ~byte_mask) | (wdata & byte_mask);
      if (mask_hit) irq_mask <= (irq_mask & ~byte_mask) | (wdata & byte_mask);
      // New events are OR-ed in after the clear so a same-cycle set wins.
      irq_pend <= (irq_pend & ~pend_clr) | irq_event;
    end
  end

  assign irq = |(irq_pend & irq_mask);

endmodule

// File: tb/tb_axi_config_regbank.sv
// Self-checking bench for axi_config_regbank: directed vector table, reset-during-read
// sequence and randomized traffic checked against an array-based reference model.
module tb_axi_config_regbank;

  localparam int          NC      = 4;
  localparam logic [31:0] BASE    = 32'h0000_0100;
  localparam logic [31:0] RST_VAL = 32'hA5A5_0000;
  localparam logic [31:0] VER     = 32'h0001_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      raddr, waddr, wdata, status_in, irq_event, rdata;
  logic             rd, wr, rvalid, irq;
  logic [3:0]       wstrb, ctrl_wr_pulse;
  logic [NC*32-1:0] ctrl_out;

  int checks = 0;
  int errors = 0;

  axi_config_regbank #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .NUM_CTRL(NC),
    .CTRL_RESET(RST_VAL), .VERSION(VER), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rd(rd), .rdata(rdata), .rvalid(rvalid),
    .wr(wr), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .ctrl_out(ctrl_out),
    .ctrl_wr_pulse(ctrl_wr_pulse), .status_in(status_in), .irq_event(irq_event), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] raddr;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] status;
    logic [31:0] evt;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic        exp_irq;
    logic [3:0]  exp_pulse;
  } vec_t;

  // Reference model state
  logic [31:0] m_ctrl [NC];
  logic [31:0] m_pend, m_mask, m_rdata;
  logic        m_rvalid;
  logic [3:0]  m_pulse;

  function automatic logic [31:0] ad(input int idx);
    return BASE + 32'(idx * 4);
  endfunction

  function automatic int word_index(input logic [31:0] a);
    if (a < BASE) return -1;
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] bytes_of(input logic [3:0] s);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [NC*32-1:0] m_flat();
    logic [NC*32-1:0] f = '0;
    for (int k = 0; k < NC; k++) f[k*32 +: 32] = m_ctrl[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) m_ctrl[k] = RST_VAL;
    m_pend = '0; m_mask = '0; m_rdata = '0; m_rvalid = 1'b0; m_pulse = '0;
  endtask

  task automatic model_step(input vec_t v);
    int ri, wi;
    logic [31:0] bm;
    ri = word_index(v.raddr);
    wi = word_index(v.waddr);
    bm = bytes_of(v.wstrb);
    m_rvalid = v.rd;
    if (v.rd) begin
      if (ri >= 0 && ri < NC) m_rdata = m_ctrl[ri];
      else if (ri == NC)      m_rdata = v.status;
      else if (ri == NC + 1)  m_rdata = m_pend;
      else if (ri == NC + 2)  m_rdata = m_mask;
      else if (ri == NC + 3)  m_rdata = VER;
      else                    m_rdata = '0;
    end
    m_pulse = '0;
    if (v.wr) begin
      if (wi >= 0 && wi < NC) begin
        m_ctrl[wi]  = (m_ctrl[wi] & ~bm) | (v.wdata & bm);
        m_pulse[wi] = 1'b1;
      end
      if (wi == NC + 1) m_pend = m_pend & ~(v.wdata & bm);
      if (wi == NC + 2) m_mask = (m_mask & ~bm) | (v.wdata & bm);
    end
    m_pend = m_pend | v.evt;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rd = v.rd; raddr = v.raddr; wr = v.wr; waddr = v.waddr; wdata = v.wdata;
    wstrb = v.wstrb; status_in = v.status; irq_event = v.evt;
  endtask

  task automatic idle();
    rd = 0; raddr = '0; wr = 0; waddr = '0; wdata = '0; wstrb = '0;
    status_in = '0; irq_event = '0;
  endtask

  function automatic vec_t mk(input logic r, input logic [31:0] ra, input logic w,
                              input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                              input logic [31:0] st, input logic [31:0] ev, input logic erv,
                              input logic [31:0] erd, input logic eirq, input logic [3:0] ep);
    vec_t v;
    v.rd = r; v.raddr = ra; v.wr = w; v.waddr = wa; v.wdata = wd; v.wstrb = ws;
    v.status = st; v.evt = ev; v.exp_rvalid = erv; v.exp_rdata = erd;
    v.exp_irq = eirq; v.exp_pulse = ep;
    return v;
  endfunction

  vec_t tab [$];

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rvalid", 128'(rvalid), 128'(1'b0));
    check("reset_rdata", 128'(rdata), 128'(32'h0));
    check("reset_ctrl_out", 128'(ctrl_out), 128'({NC{RST_VAL}}));
    check("reset_pulse", 128'(ctrl_wr_pulse), 128'(4'b0));
    check("reset_irq", 128'(irq), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table: inputs for one cycle, expected outputs right after the edge.
    tab.push_back(mk(1, ad(7), 0, 0, 0, 0, 0, 0,                      1, VER, 0, 4'b0000));
    tab.push_back(mk(0, 0, 1, ad(2), 32'h0, 4'hF, 0, 0,               0, VER, 0, 4'b0100));
    tab.push_back(mk(0, 0, 1, ad(2), 32'h1122_3344, 4'b0101, 0, 0,    0, VER, 0, 4'b0100));
    tab.push_back(mk(1, ad(2), 0, 0, 0, 0, 0, 0,                      1, 32'h0022_0044, 0, 0));
    tab.push_back(mk(1, ad(0), 0, 0, 0, 0, 32'hCAFE, 0,               1, RST_VAL, 0, 0));
    tab.push_back(mk(1, ad(1), 0, 0, 0, 0, 32'hCAFE, 0,               1, RST_VAL, 0, 0));
    tab.push_back(mk(1, ad(4), 0, 0, 0, 0, 32'hCAFE, 0,               1, 32'hCAFE, 0, 0));
    tab.push_back(mk(1, ad(9), 0, 0, 0, 0, 32'hCAFE, 0,               1, 32'h0, 0, 0));
    tab.push_back(mk(0, 0, 1, ad(6), 32'h1, 4'hF, 0, 0,               0, 32'h0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h3,                      0, 32'h0, 1, 0));
    tab.push_back(mk(1, ad(5), 0, 0, 0, 0, 0, 0,                      1, 32'h3, 1, 0));
    tab.push_back(mk(0, 0, 1, ad(5), 32'h1, 4'hF, 0, 0,               0, 32'h3, 0, 0));
    tab.push_back(mk(1, ad(5), 0, 0, 0, 0, 0, 0,                      1, 32'h2, 0, 0));
    tab.push_back(mk(0, 0, 1, ad(5), 32'h1, 4'hF, 0, 32'h1,           0, 32'h2, 1, 0));
    tab.push_back(mk(1, ad(5), 0, 0, 0, 0, 0, 0,                      1, 32'h3, 1, 0));
    tab.push_back(mk(0, 0, 1, ad(5), 32'h3, 4'hF, 0, 0,               0, 32'h3, 0, 0));
    tab.push_back(mk(1, ad(0), 1, ad(0), 32'hFFFF_FFFF, 4'hF, 0, 0,   1, RST_VAL, 0, 4'b0001));
    tab.push_back(mk(1, ad(0), 0, 0, 0, 0, 0, 0,                      1, 32'hFFFF_FFFF, 0, 0));
    tab.push_back(mk(1, BASE - 32'd4, 0, 0, 0, 0, 0, 0,               1, 32'h0, 0, 0));
    tab.push_back(mk(0, 0, 1, ad(7), 32'h0, 4'hF, 0, 0,               0, 32'h0, 0, 0));
    tab.push_back(mk(1, ad(7), 0, 0, 0, 0, 0, 0,                      1, VER, 0, 0));
    tab.push_back(mk(1, ad(2) + 32'd3, 0, 0, 0, 0, 0, 0,              1, 32'h0022_0044, 0, 0));
    tab.push_back(mk(0, 0, 1, ad(1), 32'h1234_5678, 4'h0, 0, 0,       0, 32'h0022_0044, 0, 4'b0010));
    tab.push_back(mk(1, ad(1), 0, 0, 0, 0, 0, 0,                      1, RST_VAL, 0, 0));

    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i]);
      model_step(tab[i]);
      @(posedge clk); #1;
      check($sformatf("tab%0d_rvalid", i), 128'(rvalid), 128'(tab[i].exp_rvalid));
      check($sformatf("tab%0d_rdata", i), 128'(rdata), 128'(tab[i].exp_rdata));
      check($sformatf("tab%0d_irq", i), 128'(irq), 128'(tab[i].exp_irq));
      check($sformatf("tab%0d_pulse", i), 128'(ctrl_wr_pulse), 128'(tab[i].exp_pulse));
      check($sformatf("tab%0d_ctrl_out", i), 128'(ctrl_out), 128'(m_flat()));
    end

    // Reset arriving while a read response is on the outputs: dropped immediately.
    begin
      vec_t v;
      v = mk(0, 0, 0, 0, 0, 0, 0, 32'h1, 0, 0, 0, 0);
      drive(v); model_step(v);
      @(posedge clk); #1;
      check("pre_rst_irq", 128'(irq), 128'(1'b1));
      v = mk(1, ad(3), 1, ad(3), 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 0);
      drive(v); model_step(v);
      @(posedge clk); #1;
      check("pre_rst_rvalid", 128'(rvalid), 128'(1'b1));
      idle();
      rst = 1'b1;
      #1;
      check("rst_async_rvalid", 128'(rvalid), 128'(1'b0));
      check("rst_async_rdata", 128'(rdata), 128'(32'h0));
      check("rst_async_ctrl", 128'(ctrl_out), 128'({NC{RST_VAL}}));
      check("rst_async_pulse", 128'(ctrl_wr_pulse), 128'(4'b0));
      check("rst_async_irq", 128'(irq), 128'(1'b0));
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_rvalid", 128'(rvalid), 128'(1'b0));
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.rd     = $urandom_range(0, 1) == 1;
      v.wr     = $urandom_range(0, 1) == 1;
      v.raddr  = ($urandom_range(0, 15) == 0) ? BASE - 32'($urandom_range(1, 16))
                                              : ad($urandom_range(0, 10)) + 32'($urandom_range(0, 3));
      v.waddr  = ($urandom_range(0, 15) == 0) ? BASE - 32'($urandom_range(1, 16))
                                              : ad($urandom_range(0, 10)) + 32'($urandom_range(0, 3));
      v.wdata  = $urandom;
      v.wstrb  = 4'($urandom);
      v.status = $urandom;
      v.evt    = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
      drive(v);
      model_step(v);
      @(posedge clk); #1;
      check($sformatf("rnd%0d_rvalid", n), 128'(rvalid), 128'(m_rvalid));
      check($sformatf("rnd%0d_rdata", n), 128'(rdata), 128'(m_rdata));
      check($sformatf("rnd%0d_irq", n), 128'(irq), 128'(|(m_pend & m_mask)));
      check($sformatf("rnd%0d_pulse", n), 128'(ctrl_wr_pulse), 128'(m_pulse));
      check($sformatf("rnd%0d_ctrl_out", n), 128'(ctrl_out), 128'(m_flat()));
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
